// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin two-port arbiter in front of a shared Block RAM, with
//            lockable bounded bursts and 1-cycle read response routing.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  req_0,
    input  logic                  lock_0,
    input  logic [3:0]            we_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [31:0]           wdata_0,
    output logic                  gnt_0,
    output logic                  rvalid_0,
    output logic [31:0]           rdata_0,
    input  logic                  req_1,
    input  logic                  lock_1,
    input  logic [3:0]            we_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [31:0]           wdata_1,
    output logic                  gnt_1,
    output logic                  rvalid_1,
    output logic [31:0]           rdata_1,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    input  logic [31:0]           ram_doutb
);

    localparam int              c_BCNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_BCNT_W-1:0] c_BMAX = c_BCNT_W'(MAX_BURST);
    localparam logic [c_BCNT_W-1:0] c_BONE = c_BCNT_W'(1);
    localparam logic [1:0]      c_OWN_NONE = 2'd0;
    localparam logic [1:0]      c_OWN_0    = 2'd1;
    localparam logic [1:0]      c_OWN_1    = 2'd2;

    logic                  r_last;
    logic [1:0]            r_owner;
    logic [c_BCNT_W-1:0]   r_bcnt;
    logic                  r_pend_0, r_pend_1;
    logic                  r_rvalid_0, r_rvalid_1;
    logic [31:0]           r_rdata_0, r_rdata_1;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [31:0]           r_din_q;

    logic                  w_gnt_0, w_gnt_1, w_any, w_sel, w_lock;
    logic [3:0]            w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_wdata;
    logic [1:0]            w_own_new;

    // Owner priority first, then the round-robin tie-break on r_last.
    always_comb begin
        w_gnt_0 = 1'b0;
        w_gnt_1 = 1'b0;
        if (rst) begin
            w_gnt_0 = 1'b0;
            w_gnt_1 = 1'b0;
        end else if (r_owner == c_OWN_0 && req_0) begin
            if (r_bcnt == c_BMAX && req_1) w_gnt_1 = 1'b1;
            else                           w_gnt_0 = 1'b1;
        end else if (r_owner == c_OWN_1 && req_1) begin
            if (r_bcnt == c_BMAX && req_0) w_gnt_0 = 1'b1;
            else                           w_gnt_1 = 1'b1;
        end else if (req_0 && req_1) begin
            if (r_last) w_gnt_0 = 1'b1;
            else        w_gnt_1 = 1'b1;
        end else begin
            w_gnt_0 = req_0;
            w_gnt_1 = req_1;
        end
    end

    assign w_any     = w_gnt_0 | w_gnt_1;
    assign w_sel     = w_gnt_1;
    assign w_lock    = w_sel ? lock_1  : lock_0;
    assign w_we      = w_sel ? we_1    : we_0;
    assign w_addr    = w_sel ? addr_1  : addr_0;
    assign w_wdata   = w_sel ? wdata_1 : wdata_0;
    assign w_own_new = w_sel ? c_OWN_1 : c_OWN_0;

    assign gnt_0     = w_gnt_0;
    assign gnt_1     = w_gnt_1;
    assign ram_addra = w_any ? w_addr  : r_addr_q;
    assign ram_addrb = w_any ? w_addr  : r_addr_q;
    assign ram_dina  = w_any ? w_wdata : r_din_q;
    assign ram_wea   = w_any ? w_we    : 4'b0000;
    assign rvalid_0  = r_rvalid_0;
    assign rvalid_1  = r_rvalid_1;
    assign rdata_0   = r_rdata_0;
    assign rdata_1   = r_rdata_1;

    always_ff @(posedge clka) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_owner    <= c_OWN_NONE;
            r_bcnt     <= '0;
            r_pend_0   <= 1'b0;
            r_pend_1   <= 1'b0;
            r_rvalid_0 <= 1'b0;
            r_rvalid_1 <= 1'b0;
            r_rdata_0  <= '0;
            r_rdata_1  <= '0;
            r_addr_q   <= '0;
            r_din_q    <= '0;
        end else begin
            // RAM output is valid the cycle after the grant edge.
            r_rvalid_0 <= r_pend_0;
            r_rvalid_1 <= r_pend_1;
            if (r_pend_0) r_rdata_0 <= ram_doutb;
            if (r_pend_1) r_rdata_1 <= ram_doutb;
            r_pend_0 <= w_gnt_0 && (we_0 == 4'b0000);
            r_pend_1 <= w_gnt_1 && (we_1 == 4'b0000);
            if (w_any) begin
                r_last   <= w_sel;
                r_addr_q <= w_addr;
                r_din_q  <= w_wdata;
                if (w_lock) begin
                    r_owner <= w_own_new;
                    if (r_owner != w_own_new) r_bcnt <= c_BONE;
                    else if (r_bcnt != c_BMAX) r_bcnt <= r_bcnt + c_BONE;
                end else begin
                    r_owner <= c_OWN_NONE;
                    r_bcnt  <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-clock dual-address code/data Block RAM between the Cortex-M0 bus bridge (port 0) and the SD-card code loader (port 1). It accepts at most one word access per cycle, drives the RAM write and read ports from the granted requester, and returns read data to the correct requester one cycle later. Arbitration is round-robin. A lock input lets a requester hold the RAM for a bounded burst.

## Interface
Parameters:
- ADDR_WIDTH, 10, word address width; matches the Block RAM depth of 2**ADDR_WIDTH words
- MAX_BURST, 16, maximum consecutive locked grants before yielding to a waiting requester; legal range 2..255

Ports (n = 0, 1):
- clka  in  1  system clock; the RAM runs on the same clock
- rst  in  1  synchronous, active-high reset
- req_n  in  1  access request; held, with its fields stable, until granted
- lock_n  in  1  request to keep ownership on following cycles (burst)
- we_n  in  4  byte write enables; 4'b0000 means read
- addr_n  in  ADDR_WIDTH  word address
- wdata_n  in  32  write data
- gnt_n  out  1  combinational; the access is taken on the rising edge where req_n & gnt_n
- rvalid_n  out  1  read data valid, one cycle after a granted read
- rdata_n  out  32  read data; held until the next rvalid_n
- ram_addra  out  ADDR_WIDTH  to RAM write address
- ram_addrb  out  ADDR_WIDTH  to RAM read address
- ram_dina  out  32  to RAM write data
- ram_wea  out  4  to RAM byte enables
- ram_doutb  in  32  from RAM, registered with 1-cycle read latency

## Operation
- Reset: gnt_0 = gnt_1 = 0 while rst is high. Also at reset: rvalid_n = 0, rdata_n = 0, ram_wea = 0, ram_addra = ram_addrb = 0, last = 1 (so port 0 wins the first tie), owner = none, bcnt = 0.
- Grant rules, evaluated each cycle:
  - Exactly one requester → it is granted.
  - Both requesting, no active owner → grant goes to the port that is not `last`.
  - Active owner (owner = n, lock_n was high at its previous grant, req_n high) → keep granting n while bcnt < MAX_BURST.
  - Active owner with bcnt == MAX_BURST and the other port requesting → grant the other port for that cycle; ownership is cleared.
  - Active owner with bcnt == MAX_BURST and the other port idle → n keeps the grant; bcnt saturates at MAX_BURST.
- On each granted edge:
  - last ← granted port.
  - If lock is high: owner ← granted port. bcnt ← bcnt + 1 if same owner, else 1.
  - If lock is low: owner ← none, bcnt ← 0.
- RAM drive, combinational from the granted port:
  - ram_addra = ram_addrb = addr.
  - ram_dina = wdata.
  - ram_wea = we.
  - No grant → ram_wea = 0; addresses and data hold their previous values (registered mirror).
- Reads: a granted access with we == 0 sets pending_n. On the next cycle rvalid_n = 1 and rdata_n is captured from ram_doutb. rdata_n holds until the next read completes on that port.
- Writes produce no response. The byte lanes with we[i] = 1 update on the grant edge.
- Partial-write-then-read: a read granted in the cycle after a write to the same address returns the new data. Required; the two accesses are sequential.
- A requester must not drop req_n before it is granted. If it does, nothing is issued and no error is flagged.

## Timing
- Grant latency: 0 cycles when uncontended (gnt_n in the same cycle as req_n).
- Worst-case wait: 1 cycle unlocked; MAX_BURST cycles against a locked owner.
- Read latency: rvalid_n asserts exactly 1 cycle after the grant edge.
- Throughput: 1 access per cycle total. Back-to-back grants to the same port are legal every cycle.
- Simultaneous req_0 & req_1 in the first cycle after reset → port 0 is granted.
- Reset mid-burst or mid-read: on the reset edge the pending read is squashed (rvalid_n stays 0), and owner and bcnt clear.
- Lock is ignored on a non-granted cycle.
- Lock deasserted while owning → ownership releases after that grant.

## Test plan
- Port 0 alone: writes 32'hDEADBEEF to address 5, we = 4'hF; next cycle reads address 5 → rvalid_0 one cycle after the read grant, rdata_0 = 32'hDEADBEEF, rvalid_1 stays 0.
- Byte lanes: write 32'h11223344 with we = 4'hF, then 32'hAABBCCDD with we = 4'b0101 to the same address; read back → 32'h11BB33DD.
- Contention, no lock: both ports request reads every cycle for 8 cycles → grants alternate 0,1,0,1…; each rvalid_n carries the data for its own address.
- Burst lock with MAX_BURST = 16: port 1 locks and requests; port 0 requests from cycle 3 → port 1 is granted 16 consecutive cycles, port 0 gets the 17th, port 1 resumes on the 18th.
- Lock saturation: port 1 locks for 40 cycles with port 0 idle → 40 consecutive grants, bcnt stays at 16; port 0 then requests → granted on the next cycle.
- Reset mid-read: assert rst in the cycle after a granted read → rvalid_n stays 0, gnt_n = 0 during reset; the first tie after reset goes to port 0.
